// File: rtl/commit_trace_unit.sv
// commit_trace_unit: captures one commit record per retired instruction into a FIFO,
// with instruction/cycle/drop counters, a cycle-limit watchdog and sticky status.
module commit_trace_unit #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     retire_vld,
    input  logic [DATA_W-1:0]        retire_pc,
    input  logic                     retire_reg_write,
    input  logic [3:0]               retire_write_reg,
    input  logic [DATA_W-1:0]        retire_write_data,
    input  logic                     retire_mem_read,
    input  logic                     retire_mem_write,
    input  logic [DATA_W-1:0]        retire_mem_addr,
    input  logic [DATA_W-1:0]        retire_mem_data,
    input  logic                     retire_halt,
    output logic                     trc_vld,
    input  logic                     trc_rdy,
    output logic [CNT_W-1:0]         trc_inum,
    output logic [DATA_W-1:0]        trc_pc,
    output logic [1:0]               trc_kind,
    output logic                     trc_load,
    output logic [3:0]               trc_reg,
    output logic [DATA_W-1:0]        trc_value,
    output logic [DATA_W-1:0]        trc_addr,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         inst_count,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow,
    output logic                     halted,
    output logic                     timeout,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [CNT_W-1:0]  inum;
        logic [DATA_W-1:0] pc;
        logic [1:0]        kind;
        logic              load;
        logic [3:0]        rgn;
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] addr;
    } rec_t;

    rec_t              r_mem [DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [LW-1:0]     r_level;
    logic [CNT_W-1:0]  r_inst, r_cycle, r_drop;
    logic              r_ovf, r_halted, r_timeout;

    rec_t              w_rec, w_head;
    logic [1:0]        w_kind;
    logic              w_acc, w_pop, w_full, w_push, w_drop, w_run;
    logic [CNT_W-1:0]  w_cyc_inc;

    assign w_kind = retire_reg_write ? 2'd1 : retire_halt ? 2'd3 : retire_mem_write ? 2'd2 : 2'd0;
    assign w_rec  = '{
        inum:  r_inst,
        pc:    retire_pc,
        kind:  w_kind,
        load:  retire_reg_write & retire_mem_read,
        rgn:   (w_kind == 2'd1) ? retire_write_reg : 4'd0,
        value: (w_kind == 2'd1) ? retire_write_data : (w_kind == 2'd2) ? retire_mem_data : '0,
        addr:  (retire_mem_read | retire_mem_write) ? retire_mem_addr : '0
    };

    assign w_run     = ~r_halted & ~r_timeout;
    assign w_acc     = retire_vld & w_run;
    assign trc_vld   = r_level != '0;
    assign w_pop     = trc_vld & trc_rdy;
    assign w_full    = r_level == LW'(DEPTH);
    // a full FIFO still takes the record when the head leaves in the same cycle
    assign w_push    = w_acc & (~w_full | w_pop);
    assign w_drop    = w_acc & ~w_push;
    assign w_cyc_inc = r_cycle + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_inst    <= '0;
            r_cycle   <= '0;
            r_drop    <= '0;
            r_ovf     <= 1'b0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
        end else if (clr) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_inst    <= '0;
            r_cycle   <= '0;
            r_drop    <= '0;
            r_ovf     <= 1'b0;
            r_halted  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (w_acc) r_inst <= r_inst + 1'b1;
            if (w_drop) begin
                r_drop <= (&r_drop) ? r_drop : r_drop + 1'b1;
                r_ovf  <= 1'b1;
            end
            if (w_acc && w_kind == 2'd3) r_halted <= 1'b1;
            if (w_run) begin
                r_cycle <= w_cyc_inc;
                if (w_cyc_inc == CNT_W'(CYCLE_LIMIT)) r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_rec;
    end

    assign w_head      = trc_vld ? r_mem[r_rptr] : '0;
    assign trc_inum    = w_head.inum;
    assign trc_pc      = w_head.pc;
    assign trc_kind    = w_head.kind;
    assign trc_load    = w_head.load;
    assign trc_reg     = w_head.rgn;
    assign trc_value   = w_head.value;
    assign trc_addr    = w_head.addr;
    assign fifo_level  = r_level;
    assign inst_count  = r_inst;
    assign cycle_count = r_cycle;
    assign drop_count  = r_drop;
    assign overflow    = r_ovf;
    assign halted      = r_halted;
    assign timeout     = r_timeout;
    assign done        = r_halted & (r_level == '0);
endmodule

// File: tb/tb_commit_trace_unit.sv
// tb_commit_trace_unit: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations and a randomized phase.
module tb_commit_trace_unit;
    localparam int DW = 16, DEPTH = 8, CW = 32, LIM = 20;

    logic clk = 0, rst_n = 0, clr = 0;
    logic retire_vld = 0, retire_reg_write = 0, retire_mem_read = 0, retire_mem_write = 0, retire_halt = 0;
    logic [DW-1:0] retire_pc = 0, retire_write_data = 0, retire_mem_addr = 0, retire_mem_data = 0;
    logic [3:0] retire_write_reg = 0;
    logic trc_rdy = 0;
    logic trc_vld, trc_load, overflow, halted, timeout, done;
    logic [CW-1:0] trc_inum, inst_count, cycle_count, drop_count;
    logic [DW-1:0] trc_pc, trc_value, trc_addr;
    logic [1:0] trc_kind;
    logic [3:0] trc_reg;
    logic [$clog2(DEPTH):0] fifo_level;

    always #5 clk = ~clk;

    commit_trace_unit #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .CYCLE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .retire_vld(retire_vld), .retire_pc(retire_pc), .retire_reg_write(retire_reg_write),
        .retire_write_reg(retire_write_reg), .retire_write_data(retire_write_data),
        .retire_mem_read(retire_mem_read), .retire_mem_write(retire_mem_write),
        .retire_mem_addr(retire_mem_addr), .retire_mem_data(retire_mem_data), .retire_halt(retire_halt),
        .trc_vld(trc_vld), .trc_rdy(trc_rdy), .trc_inum(trc_inum), .trc_pc(trc_pc), .trc_kind(trc_kind),
        .trc_load(trc_load), .trc_reg(trc_reg), .trc_value(trc_value), .trc_addr(trc_addr),
        .fifo_level(fifo_level), .inst_count(inst_count), .cycle_count(cycle_count),
        .drop_count(drop_count), .overflow(overflow), .halted(halted), .timeout(timeout), .done(done)
    );

    typedef struct packed {
        logic [31:0] inum;
        logic [15:0] pc;
        logic [1:0]  kind;
        logic        load;
        logic [3:0]  rg;
        logic [15:0] value;
        logic [15:0] addr;
    } rec_t;

    int n_tests = 0, n_fail = 0;
    rec_t mq[$];
    rec_t got[$];
    rec_t h;
    bit h_vld = 0;
    int unsigned m_inst = 0, m_cyc = 0, m_drop = 0;
    bit m_halt = 0, m_to = 0, m_ovf = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        mq.delete();
        m_inst = 0; m_cyc = 0; m_drop = 0;
        m_halt = 0; m_to = 0; m_ovf = 0;
    endfunction

    task automatic m_step();
        bit full, pop, acc;
        rec_t r, t;
        if (!rst_n || clr) begin
            m_reset();
            return;
        end
        if (h_vld && trc_rdy) got.push_back(h);
        full = mq.size() == DEPTH;
        pop  = mq.size() > 0 && trc_rdy;
        acc  = retire_vld && !m_halt && !m_to;
        if (pop) t = mq.pop_front();
        r = '0;
        if (acc) begin
            r.inum  = m_inst;
            r.pc    = retire_pc;
            r.kind  = retire_reg_write ? 2'd1 : retire_halt ? 2'd3 : retire_mem_write ? 2'd2 : 2'd0;
            r.load  = retire_reg_write && retire_mem_read;
            r.rg    = r.kind == 1 ? retire_write_reg : 4'd0;
            r.value = r.kind == 1 ? retire_write_data : r.kind == 2 ? retire_mem_data : 16'd0;
            r.addr  = (retire_mem_read || retire_mem_write) ? retire_mem_addr : 16'd0;
            if (!full || pop) mq.push_back(r);
            else begin
                if (m_drop != 32'hFFFF_FFFF) m_drop++;
                m_ovf = 1;
            end
            m_inst++;
        end
        if (!m_halt && !m_to) begin
            m_cyc++;
            if (m_cyc == LIM) m_to = 1;
        end
        if (acc && r.kind == 2'd3) m_halt = 1;
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    always @(negedge clk) begin
        rec_t e;
        e = mq.size() > 0 ? mq[0] : '0;
        chk("trc_vld", trc_vld, mq.size() > 0);
        chk("trc_inum", trc_inum, e.inum);
        chk("trc_pc", trc_pc, e.pc);
        chk("trc_kind", trc_kind, e.kind);
        chk("trc_load", trc_load, e.load);
        chk("trc_reg", trc_reg, e.rg);
        chk("trc_value", trc_value, e.value);
        chk("trc_addr", trc_addr, e.addr);
        chk("fifo_level", fifo_level, mq.size());
        chk("inst_count", inst_count, m_inst);
        chk("cycle_count", cycle_count, m_cyc);
        chk("drop_count", drop_count, m_drop);
        chk("overflow", overflow, m_ovf);
        chk("halted", halted, m_halt);
        chk("timeout", timeout, m_to);
        chk("done", done, m_halt && mq.size() == 0);
        h = '{trc_inum, trc_pc, trc_kind, trc_load, trc_reg, trc_value, trc_addr};
        h_vld = trc_vld;
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(bit [15:0] pc, bit rw, bit [3:0] rg, bit [15:0] wd, bit mr, bit mw,
                       bit [15:0] ma, bit [15:0] md, bit hl);
        retire_vld = 1; retire_pc = pc; retire_reg_write = rw; retire_write_reg = rg;
        retire_write_data = wd; retire_mem_read = mr; retire_mem_write = mw;
        retire_mem_addr = ma; retire_mem_data = md; retire_halt = hl;
        cyc();
        retire_vld = 0; retire_reg_write = 0; retire_mem_read = 0; retire_mem_write = 0; retire_halt = 0;
    endtask

    task automatic idle(int n);
        repeat (n) cyc();
    endtask

    task automatic do_clr();
        clr = 1;
        cyc();
        clr = 0;
        got.delete();
    endtask

    int rdy_pct;

    initial begin
        m_reset();
        cyc();
        rst_n = 1;

        // basic records: reg write, store, nop, then a load
        do_clr();
        trc_rdy = 1;
        drv(16'h0000, 1, 4'd3, 16'h00AB, 0, 0, 16'h0, 16'h0, 0);
        drv(16'h0002, 0, 4'd0, 16'h0, 0, 1, 16'h0010, 16'h1234, 0);
        drv(16'h0004, 0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        idle(2);
        chk("t1_nrec", got.size(), 3);
        chk("t1_inum1", got[1].inum, 1);
        chk("t1_inum2", got[2].inum, 2);
        chk("t1_kind0", got[0].kind, 1);
        chk("t1_kind1", got[1].kind, 2);
        chk("t1_kind2", got[2].kind, 0);
        chk("t1_val0", got[0].value, 16'h00AB);
        chk("t1_val1", got[1].value, 16'h1234);
        chk("t1_addr1", got[1].addr, 16'h0010);
        chk("t1_addr0", got[0].addr, 0);
        chk("t1_inst", inst_count, 3);
        drv(16'h0006, 1, 4'd5, 16'hBEEF, 1, 0, 16'h0020, 16'h0, 0);
        idle(1);
        chk("t2_kind", got[3].kind, 1);
        chk("t2_load", got[3].load, 1);
        chk("t2_reg", got[3].rg, 5);
        chk("t2_val", got[3].value, 16'hBEEF);
        chk("t2_addr", got[3].addr, 16'h0020);

        // overflow with consumer stalled
        do_clr();
        trc_rdy = 0;
        for (int i = 0; i < 10; i++) drv(16'(i * 2), 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_level", fifo_level, 8);
        chk("t3_drop", drop_count, 2);
        chk("t3_ovf", overflow, 1);
        chk("t3_inst", inst_count, 10);
        trc_rdy = 1;
        idle(9);
        chk("t3_nrec", got.size(), 8);
        for (int i = 0; i < 8; i++) chk("t3_inum", got[i].inum, i);

        // full FIFO with simultaneous push and pop
        do_clr();
        trc_rdy = 0;
        for (int i = 0; i < 8; i++) drv(16'(i * 2), 0, 0, 0, 0, 0, 0, 0, 0);
        trc_rdy = 1;
        drv(16'h0040, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_level", fifo_level, 8);
        chk("t4_drop", drop_count, 0);
        chk("t4_inst", inst_count, 9);
        idle(9);
        chk("t4_nrec", got.size(), 9);
        chk("t4_inum8", got[8].inum, 8);
        chk("t4_pc8", got[8].pc, 16'h0040);

        // halt freezes counters; done after drain
        do_clr();
        trc_rdy = 0;
        for (int i = 0; i < 3; i++) drv(16'(i * 2), 1, 4'(i + 1), 16'(i), 0, 0, 0, 0, 0);
        drv(16'h0006, 0, 0, 0, 0, 0, 0, 0, 1);
        drv(16'h0008, 1, 4'd1, 16'h1, 0, 0, 0, 0, 0);
        drv(16'h000A, 1, 4'd1, 16'h1, 0, 0, 0, 0, 0);
        chk("t5_halted", halted, 1);
        chk("t5_inst", inst_count, 4);
        chk("t5_done0", done, 0);
        idle(2);
        chk("t5_cycle", cycle_count, 4);
        trc_rdy = 1;
        idle(5);
        chk("t5_done1", done, 1);
        chk("t5_nrec", got.size(), 4);
        chk("t5_kind3", got[3].kind, 3);
        chk("t5_pc3", got[3].pc, 16'h0006);

        // watchdog
        do_clr();
        trc_rdy = 0;
        idle(25);
        chk("t6_timeout", timeout, 1);
        chk("t6_cycle", cycle_count, 20);
        drv(16'h0002, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_inst", inst_count, 0);
        chk("t6_vld", trc_vld, 0);
        do_clr();
        idle(19);
        drv(16'h0004, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_edge_to", timeout, 1);
        chk("t6_edge_inst", inst_count, 1);
        chk("t6_edge_lvl", fifo_level, 1);

        // asynchronous reset mid-run
        do_clr();
        for (int i = 0; i < 3; i++) drv(16'(i * 2), 1, 4'd2, 16'h55, 0, 0, 0, 0, 0);
        #2;
        rst_n = 0;
        m_reset();
        #1;
        chk("t7_vld", trc_vld, 0);
        chk("t7_pc", trc_pc, 0);
        chk("t7_level", fifo_level, 0);
        chk("t7_inst", inst_count, 0);
        chk("t7_cycle", cycle_count, 0);
        chk("t7_drop", drop_count, 0);
        cyc();
        rst_n = 1;

        // randomized traffic
        rdy_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) rdy_pct = $urandom_range(0, 100);
            retire_vld        = $urandom_range(0, 99) < 70;
            retire_pc         = 16'($urandom);
            retire_reg_write  = $urandom_range(0, 1) == 1;
            retire_write_reg  = 4'($urandom);
            retire_write_data = 16'($urandom);
            retire_mem_read   = $urandom_range(0, 2) == 0;
            retire_mem_write  = $urandom_range(0, 2) == 0;
            retire_mem_addr   = 16'($urandom);
            retire_mem_data   = 16'($urandom);
            retire_halt       = $urandom_range(0, 19) == 0;
            trc_rdy           = $urandom_range(0, 99) < rdy_pct;
            clr               = $urandom_range(0, 29) == 0;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 0;
                m_reset();
                #1;
                rst_n = 1;
            end
            cyc();
        end
        clr = 0;
        retire_vld = 0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
